// File: rtl/bresenham.sv
// Bresenham line rasteriser: walks from (x0,y0) to (x1,y1) inclusive, one
// pixel per enabled clock, with a start/busy/done handshake and clk_en pacing.
module bresenham #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clk_en,
   input  logic         start,
   input  logic [W-1:0] x0,
   input  logic [W-1:0] y0,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] y1,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         plot,
   output logic         busy,
   output logic         done
);

   // Two guard bits: |delta| needs W+1 bits plus sign.
   localparam int EW = W + 2;

   typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_DRAW, ST_DONE} state_t;

   state_t                state, state_n;
   logic [W-1:0]          lx0, ly0, lx1, ly1;
   logic [W-1:0]          lx0_n, ly0_n, lx1_n, ly1_n;
   logic [W-1:0]          x_n, y_n;
   logic                  plot_n, busy_n, done_n;
   logic signed [EW-1:0]  dx, dy, err;
   logic signed [EW-1:0]  dx_n, dy_n, err_n;
   logic                  sx_neg, sy_neg, sx_neg_n, sy_neg_n;

   logic signed [EW-1:0]  adx, ady;
   logic signed [EW:0]    e2, dx_e, dy_e;
   logic                  step_x, step_y;

   // Absolute difference of two unsigned coordinates, widened to EW signed bits.
   function automatic logic signed [EW-1:0] abs_diff(input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
      logic signed [EW-1:0] d;
      d = signed'({2'b00, a}) - signed'({2'b00, b});
      return (d < 0) ? -d : d;
   endfunction

   assign adx    = abs_diff(lx1, lx0);
   assign ady    = abs_diff(ly1, ly0);
   // e2 is kept one bit wider than err so doubling can never wrap.
   assign e2     = signed'({err, 1'b0});
   assign dx_e   = signed'({dx[EW-1], dx});
   assign dy_e   = signed'({dy[EW-1], dy});
   assign step_x = (e2 >= dy_e);
   assign step_y = (e2 <= dx_e);

   // Next-state and next-output logic; every register defaults to holding.
   always_comb begin
      state_n  = state;
      lx0_n    = lx0;
      ly0_n    = ly0;
      lx1_n    = lx1;
      ly1_n    = ly1;
      x_n      = x;
      y_n      = y;
      plot_n   = plot;
      busy_n   = busy;
      done_n   = done;
      dx_n     = dx;
      dy_n     = dy;
      err_n    = err;
      sx_neg_n = sx_neg;
      sy_neg_n = sy_neg;
      case (state)
         ST_IDLE: begin
            plot_n = 1'b0;
            done_n = 1'b0;
            if (start) begin
               lx0_n   = x0;
               ly0_n   = y0;
               lx1_n   = x1;
               ly1_n   = y1;
               busy_n  = 1'b1;
               state_n = ST_INIT;
            end
         end
         ST_INIT: begin
            dx_n     = adx;
            dy_n     = -ady;
            sx_neg_n = !(lx0 < lx1);
            sy_neg_n = !(ly0 < ly1);
            err_n    = adx - ady;
            x_n      = lx0;
            y_n      = ly0;
            plot_n   = 1'b1;
            state_n  = ST_DRAW;
         end
         ST_DRAW: begin
            if (x == lx1 && y == ly1) begin
               plot_n  = 1'b0;
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = ST_DONE;
            end else begin
               // Both axis decisions use the pre-update err.
               err_n = err + (step_x ? dy : '0) + (step_y ? dx : '0);
               if (step_x) x_n = sx_neg ? x - W'(1) : x + W'(1);
               if (step_y) y_n = sy_neg ? y - W'(1) : y + W'(1);
            end
         end
         ST_DONE: begin
            done_n  = 1'b0;
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset wins over clk_en, clk_en=0 holds all.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         lx0    <= '0;
         ly0    <= '0;
         lx1    <= '0;
         ly1    <= '0;
         x      <= '0;
         y      <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         dx     <= '0;
         dy     <= '0;
         err    <= '0;
         sx_neg <= 1'b0;
         sy_neg <= 1'b0;
      end else if (clk_en) begin
         state  <= state_n;
         lx0    <= lx0_n;
         ly0    <= ly0_n;
         lx1    <= lx1_n;
         ly1    <= ly1_n;
         x      <= x_n;
         y      <= y_n;
         plot   <= plot_n;
         busy   <= busy_n;
         done   <= done_n;
         dx     <= dx_n;
         dy     <= dy_n;
         err    <= err_n;
         sx_neg <= sx_neg_n;
         sy_neg <= sy_neg_n;
      end
   end

endmodule

// File: tb/tb_bresenham.sv
// Directed testbench for the bresenham line rasteriser.
module tb_bresenham;

   logic       clk = 1'b0;
   logic       reset, clk_en, start;
   logic [9:0] x0, y0, x1, y1;
   logic [9:0] x, y;
   logic       plot, busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   int px[$];
   int py[$];
   int first_cyc;
   int timed_out;
   int hold_err;

   bresenham #(.W(10)) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .x(x), .y(y), .plot(plot), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Issue one start and capture every clk_en-qualified pixel until done.
   task automatic draw(input int ax, input int ay, input int bx, input int by,
                       input bit toggle, input int max_cyc);
      logic       en_edge;
      logic [9:0] pxv, pyv;
      logic       pplot;
      px.delete();
      py.delete();
      first_cyc = -1;
      timed_out = 1;
      hold_err  = 0;
      @(posedge clk); #1;
      x0 = 10'(ax); y0 = 10'(ay); x1 = 10'(bx); y1 = 10'(by);
      start = 1'b1;
      clk_en = 1'b1;
      pxv = x; pyv = y; pplot = plot;
      for (int c = 1; c <= max_cyc; c++) begin
         en_edge = clk_en;
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
         if (!en_edge && (x !== pxv || y !== pyv || plot !== pplot)) hold_err++;
         pxv = x; pyv = y; pplot = plot;
         clk_en = toggle ? ~clk_en : 1'b1;
         if (clk_en) begin
            if (plot) begin
               if (first_cyc < 0) first_cyc = c;
               px.push_back(int'(x));
               py.push_back(int'(y));
            end
            if (done) begin
               timed_out = 0;
               break;
            end
         end
      end
      clk_en = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clk_en = 1'b0; start = 1'b0;
      x0 = '0; y0 = '0; x1 = '0; y1 = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (x !== 10'd0)  begin n_bad++; $display("FAIL reset_x got %0d want 0", x); end
      n_cmp++; if (y !== 10'd0)  begin n_bad++; $display("FAIL reset_y got %0d want 0", y); end
      n_cmp++; if (plot !== 1'b0) begin n_bad++; $display("FAIL reset_plot got %b want 0", plot); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
      reset = 1'b0; clk_en = 1'b1;
   endtask

   task automatic test_long();
      int bad;
      draw(0, 0, 640, 480, 1'b0, 2000);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL long_timeout got %0d want 0", timed_out); end
      n_cmp++; if (px.size() !== 641) begin n_bad++; $display("FAIL long_count got %0d want 641", px.size()); end
      n_cmp++; if (first_cyc !== 2) begin n_bad++; $display("FAIL long_latency got %0d want 2", first_cyc); end
      if (px.size() > 0) begin
         n_cmp++; if (px[0] !== 0 || py[0] !== 0) begin n_bad++; $display("FAIL long_first got (%0d,%0d) want (0,0)", px[0], py[0]); end
         n_cmp++; if (px[$] !== 640 || py[$] !== 480) begin n_bad++; $display("FAIL long_last got (%0d,%0d) want (640,480)", px[$], py[$]); end
      end
      bad = 0;
      for (int i = 0; i < px.size(); i++) begin
         if (px[i] !== i) bad++;
         if (i > 0 && (py[i] < py[i-1] || py[i] - py[i-1] > 1)) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL long_path got %0d bad steps want 0", bad); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy_at_done got %b want 0", busy); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL long_done_pulse got %b want 0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL long_busy_after got %b want 0", busy); end
   endtask

   task automatic test_single();
      draw(5, 7, 5, 7, 1'b0, 20);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL single_timeout got %0d want 0", timed_out); end
      n_cmp++; if (px.size() !== 1) begin n_bad++; $display("FAIL single_count got %0d want 1", px.size()); end
      if (px.size() > 0) begin
         n_cmp++; if (px[0] !== 5 || py[0] !== 7) begin n_bad++; $display("FAIL single_pixel got (%0d,%0d) want (5,7)", px[0], py[0]); end
      end
      n_cmp++; if (plot !== 1'b0) begin n_bad++; $display("FAIL single_plot_at_done got %b want 0", plot); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse got %b want 0", done); end
   endtask

   task automatic test_steep();
      int bad;
      draw(100, 10, 90, 40, 1'b0, 100);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL steep_timeout got %0d want 0", timed_out); end
      n_cmp++; if (px.size() !== 31) begin n_bad++; $display("FAIL steep_count got %0d want 31", px.size()); end
      bad = 0;
      for (int i = 0; i < px.size(); i++) begin
         if (py[i] !== 10 + i) bad++;
         if (px[i] < 90 || px[i] > 100) bad++;
         if (i > 0 && (px[i] > px[i-1] || px[i-1] - px[i] > 1)) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL steep_path got %0d bad steps want 0", bad); end
      if (px.size() > 0) begin
         n_cmp++; if (px[0] !== 100 || py[0] !== 10) begin n_bad++; $display("FAIL steep_first got (%0d,%0d) want (100,10)", px[0], py[0]); end
         n_cmp++; if (px[$] !== 90 || py[$] !== 40) begin n_bad++; $display("FAIL steep_last got (%0d,%0d) want (90,40)", px[$], py[$]); end
      end
   endtask

   task automatic test_horizontal();
      int bad;
      draw(20, 3, 10, 3, 1'b0, 50);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL horiz_timeout got %0d want 0", timed_out); end
      n_cmp++; if (px.size() !== 11) begin n_bad++; $display("FAIL horiz_count got %0d want 11", px.size()); end
      bad = 0;
      for (int i = 0; i < px.size(); i++)
         if (px[i] !== 20 - i || py[i] !== 3) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL horiz_path got %0d bad pixels want 0", bad); end
   endtask

   task automatic test_clk_en();
      int ex[4] = '{0, 1, 2, 3};
      int ey[4] = '{0, 0, 1, 1};
      draw(0, 0, 3, 1, 1'b1, 60);
      n_cmp++; if (timed_out !== 0) begin n_bad++; $display("FAIL clken_timeout got %0d want 0", timed_out); end
      n_cmp++; if (px.size() !== 4) begin n_bad++; $display("FAIL clken_count got %0d want 4", px.size()); end
      for (int i = 0; i < 4 && i < px.size(); i++) begin
         n_cmp++;
         if (px[i] !== ex[i] || py[i] !== ey[i]) begin
            n_bad++;
            $display("FAIL clken_pixel%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
         end
      end
      n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL clken_hold got %0d changes want 0", hold_err); end
   endtask

   task automatic test_reset_midline();
      int ex[3] = '{2, 3, 4};
      int ey[3] = '{2, 3, 3};
      bit saw_done;
      saw_done = 1'b0;
      @(posedge clk); #1;
      clk_en = 1'b1;
      x0 = 10'd0; y0 = 10'd0; x1 = 10'd20; y1 = 10'd0;
      start = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
         if (c == 1) start = 1'b0;
         if (c == 5) begin
            start = 1'b1; x0 = 10'd50; y0 = 10'd50; x1 = 10'd60; y1 = 10'd60;
         end
         if (c == 6) start = 1'b0;
      end
      n_cmp++; if (x !== 10'd6 || y !== 10'd0) begin n_bad++; $display("FAIL midline_pos got (%0d,%0d) want (6,0)", x, y); end
      n_cmp++; if (plot !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL midline_flags got plot=%b busy=%b want 1 1", plot, busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      if (done) saw_done = 1'b1;
      n_cmp++; if (x !== 10'd0 || y !== 10'd0) begin n_bad++; $display("FAIL midreset_xy got (%0d,%0d) want (0,0)", x, y); end
      n_cmp++; if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL midreset_flags got plot=%b busy=%b done=%b want 0 0 0", plot, busy, done); end
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL midreset_no_done got %b want 0", saw_done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle_busy got %b want 0", busy); end
      draw(2, 2, 4, 3, 1'b0, 20);
      n_cmp++; if (px.size() !== 3) begin n_bad++; $display("FAIL after_reset_count got %0d want 3", px.size()); end
      for (int i = 0; i < 3 && i < px.size(); i++) begin
         n_cmp++;
         if (px[i] !== ex[i] || py[i] !== ey[i]) begin
            n_bad++;
            $display("FAIL after_reset_pixel%0d got (%0d,%0d) want (%0d,%0d)", i, px[i], py[i], ex[i], ey[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_long();
      test_single();
      test_steep();
      test_horizontal();
      test_clk_en();
      test_reset_midline();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
